// File: rtl/mem_writeback_pkg.sv
// Shared definitions for the PikaRISC memory/write-back stage: widths, FSM
// encodings and the op-class decode used to pick one action per instruction.
package mem_writeback_pkg;

  localparam int ADDR_W              = 22;
  localparam int DATA_W              = 32;
  localparam int DEFAULT_MEM_TIMEOUT = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEM  = 2'd1;
  localparam logic [1:0] ST_LDWB = 2'd2;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_LD,
    OP_STR,
    OP_ALU,
    OP_CMP,
    OP_JMP
  } op_e;

  // Several class flags may be set at once; the highest-priority one wins.
  function automatic op_e decode_op(input logic ld, input logic str, input logic alu,
                                    input logic cmp, input logic taken);
    if (ld)    return OP_LD;
    if (str)   return OP_STR;
    if (alu)   return OP_ALU;
    if (cmp)   return OP_CMP;
    if (taken) return OP_JMP;
    return OP_NOP;
  endfunction

endpackage

// File: rtl/mem_writeback.sv
// Memory/write-back stage: retires ALU/CMP/jump ops in one cycle and runs
// LD/STR over a req/ack port with a timeout. Every output is registered.
module mem_writeback
  import mem_writeback_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  // Handshake: an instruction is consumed on a cycle where in_valid && in_ready;
  // execute must hold it unchanged while in_ready is low.
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] result,
  input  logic [DATA_W-1:0] cpsr_passthrough,
  input  logic              taken,
  input  logic [DATA_W-1:0] pc_rel,
  input  logic [3:0]        rd_num_passthrough,
  input  logic [DATA_W-1:0] rd_val_passthrough,
  input  logic [ADDR_W-1:0] md_passthrough,
  input  logic              is_alu_op_passthrough,
  input  logic              is_cmp_op_passthrough,
  input  logic              is_ld_op_passthrough,
  input  logic              is_str_op_passthrough,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [3:0]        wb_rd_num,
  output logic              wb_rd_write_en,
  output logic [DATA_W-1:0] wb_rd_in,
  output logic              wb_cpsr_write_en,
  output logic [DATA_W-1:0] wb_cpsr_in,
  output logic              br_valid,
  output logic [DATA_W-1:0] br_pc_rel,
  output logic              mem_err
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    rd_q;
  op_e           op;
  logic          accept;

  assign op = decode_op(is_ld_op_passthrough, is_str_op_passthrough,
                        is_alu_op_passthrough, is_cmp_op_passthrough, taken);
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      rd_q             <= '0;
      in_ready         <= 1'b1;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      wb_rd_num        <= '0;
      wb_rd_write_en   <= 1'b0;
      wb_rd_in         <= '0;
      wb_cpsr_write_en <= 1'b0;
      wb_cpsr_in       <= '0;
      br_valid         <= 1'b0;
      br_pc_rel        <= '0;
      mem_err          <= 1'b0;
    end else begin
      wb_rd_write_en   <= 1'b0;
      wb_cpsr_write_en <= 1'b0;
      br_valid         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              OP_LD, OP_STR: begin
                state     <= ST_MEM;
                in_ready  <= 1'b0;
                mem_req   <= 1'b1;
                mem_we    <= (op == OP_STR);
                mem_addr  <= md_passthrough;
                mem_wdata <= (op == OP_STR) ? rd_val_passthrough : '0;
                rd_q      <= rd_num_passthrough;
                cnt       <= '0;
              end
              OP_ALU: begin
                wb_rd_write_en <= 1'b1;
                wb_rd_num      <= rd_num_passthrough;
                wb_rd_in       <= result;
              end
              OP_CMP: begin
                wb_cpsr_write_en <= 1'b1;
                wb_cpsr_in       <= cpsr_passthrough;
              end
              OP_JMP: begin
                br_valid  <= 1'b1;
                br_pc_rel <= pc_rel;
              end
              default: ;
            endcase
          end
        end
        ST_MEM: begin
          // An ack in the same cycle the counter would expire still completes.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              state          <= ST_LDWB;
              wb_rd_write_en <= 1'b1;
              wb_rd_num      <= rd_q;
              wb_rd_in       <= mem_rdata;
            end else begin
              state    <= ST_IDLE;
              in_ready <= 1'b1;
            end
          end else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
            cnt      <= cnt + CW'(1);
            mem_req  <= 1'b0;
            state    <= ST_IDLE;
            in_ready <= 1'b1;
            mem_err  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_LDWB: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
          mem_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_writeback.sv
// Bench for mem_writeback: directed and random instructions, expected write-backs
// predicted per cycle from the stage's retirement rules and matched by monitors.
module tb_mem_writeback;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] result, cpsr_passthrough, pc_rel, rd_val_passthrough;
  logic        taken;
  logic [3:0]  rd_num_passthrough;
  logic [21:0] md_passthrough;
  logic        is_alu, is_cmp, is_ld, is_str;
  logic        mem_req, mem_we, mem_ack;
  logic [21:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  wb_rd_num;
  logic        wb_rd_write_en, wb_cpsr_write_en, br_valid, mem_err;
  logic [31:0] wb_rd_in, wb_cpsr_in, br_pc_rel;

  mem_writeback #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .cpsr_passthrough(cpsr_passthrough), .taken(taken),
    .pc_rel(pc_rel), .rd_num_passthrough(rd_num_passthrough),
    .rd_val_passthrough(rd_val_passthrough), .md_passthrough(md_passthrough),
    .is_alu_op_passthrough(is_alu), .is_cmp_op_passthrough(is_cmp),
    .is_ld_op_passthrough(is_ld), .is_str_op_passthrough(is_str),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_rd_num(wb_rd_num),
    .wb_rd_write_en(wb_rd_write_en), .wb_rd_in(wb_rd_in),
    .wb_cpsr_write_en(wb_cpsr_write_en), .wb_cpsr_in(wb_cpsr_in),
    .br_valid(br_valid), .br_pc_rel(br_pc_rel), .mem_err(mem_err)
  );

  // Clock and cycle index; outputs are sampled 1 time unit after each rising edge.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic err_exp = 1'b0;

  // Scoreboard entries carry the sample index at which the strobe must appear.
  logic [67:0] wb_q[$];
  logic [63:0] cpsr_q[$];
  logic [63:0] br_q[$];

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always begin
    logic [67:0] we;
    logic [63:0] ce;
    logic [63:0] be;
    @(posedge clk);
    #1;
    if (wb_rd_write_en === 1'b1) begin
      if (wb_q.size() == 0) check("wb_rd_unexpected", 96'(wb_rd_write_en), 96'd0);
      else begin
        we = wb_q.pop_front();
        check("wb_rd", 96'({32'(cyc), wb_rd_num, wb_rd_in}), 96'(we));
      end
    end
    if (wb_cpsr_write_en === 1'b1) begin
      if (cpsr_q.size() == 0) check("wb_cpsr_unexpected", 96'(wb_cpsr_write_en), 96'd0);
      else begin
        ce = cpsr_q.pop_front();
        check("wb_cpsr", 96'({32'(cyc), wb_cpsr_in}), 96'(ce));
      end
    end
    if (br_valid === 1'b1) begin
      if (br_q.size() == 0) check("br_unexpected", 96'(br_valid), 96'd0);
      else begin
        be = br_q.pop_front();
        check("br", 96'({32'(cyc), br_pc_rel}), 96'(be));
      end
    end
  end

  task automatic reset_outputs_check(input string tag);
    check({tag, "_ctrl"}, 96'({in_ready, mem_req, mem_we, wb_rd_write_en, wb_cpsr_write_en,
                               br_valid, mem_err, wb_rd_num}), 96'({1'b1, 10'd0}));
    check({tag, "_mem"}, 96'({mem_addr, mem_wdata}), 96'd0);
    check({tag, "_wb"}, 96'({wb_rd_in, wb_cpsr_in, br_pc_rel}), 96'd0);
  endtask

  // Single-cycle ops: the highest set class decides the one visible effect.
  task automatic issue(input bit alu, input bit cmp, input bit tk, input logic [3:0] rd,
                       input logic [31:0] res, input logic [31:0] cps, input logic [31:0] pcr);
    check("ready_before_issue", 96'(in_ready), 96'd1);
    is_ld = 1'b0; is_str = 1'b0; is_alu = alu; is_cmp = cmp; taken = tk;
    rd_num_passthrough = rd; result = res; cpsr_passthrough = cps; pc_rel = pcr;
    rd_val_passthrough = $urandom; md_passthrough = 22'($urandom);
    in_valid = 1'b1;
    if (alu)      wb_q.push_back({32'(cyc + 1), rd, res});
    else if (cmp) cpsr_q.push_back({32'(cyc + 1), cps});
    else if (tk)  br_q.push_back({32'(cyc + 1), pcr});
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  // d = number of MEM cycles before the one in which ack is presented.
  task automatic mem_op(input bit ld, input bit noise, input logic [3:0] rd,
                        input logic [31:0] wd, input logic [21:0] addr, input int d,
                        input logic [31:0] rdata, input bit hold);
    bit done_ok;
    int n;
    check("mem_ready_before", 96'(in_ready), 96'd1);
    is_ld = ld; is_str = !ld | noise; is_alu = noise; is_cmp = noise; taken = noise;
    rd_num_passthrough = rd; rd_val_passthrough = wd; md_passthrough = addr;
    result = $urandom; in_valid = 1'b1;
    tick();
    if (hold) begin
      is_ld = 1'b0; is_str = 1'b0; is_alu = 1'b1; is_cmp = 1'b0; taken = 1'b0;
      rd_num_passthrough = 4'd5; result = 32'h55;
    end else in_valid = 1'b0;
    done_ok = (d < TO);
    n = done_ok ? d + 1 : TO;
    for (int i = 0; i < n; i++) begin
      check("mem_req_held", 96'(mem_req), 96'd1);
      check("mem_fields", 96'({mem_we, mem_addr, mem_wdata}), 96'({!ld, addr, ld ? 32'h0 : wd}));
      check("busy_not_ready", 96'(in_ready), 96'd0);
      if (done_ok && i == d) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
        if (ld) wb_q.push_back({32'(cyc + 1), rd, rdata});
      end
      tick();
      mem_ack = 1'b0;
      mem_rdata = $urandom;
    end
    check("mem_req_drop", 96'(mem_req), 96'd0);
    if (!done_ok) begin
      err_exp = 1'b1;
      check("timeout_err", 96'(mem_err), 96'd1);
      check("timeout_ready", 96'(in_ready), 96'd1);
      if (d == TO) begin
        mem_ack = 1'b1;
        mem_rdata = $urandom;
        tick();
        mem_ack = 1'b0;
        check("late_ack_ignored", 96'({mem_req, in_ready}), 96'd1);
      end
    end else if (ld) begin
      check("ld_ready_low", 96'(in_ready), 96'd0);
      tick();
      check("ld_ready_back", 96'(in_ready), 96'd1);
    end else begin
      check("str_ready_back", 96'(in_ready), 96'd1);
    end
    check("mem_err_state", 96'(mem_err), 96'(err_exp));
    if (hold) begin
      wb_q.push_back({32'(cyc + 1), 4'd5, 32'h55});
      tick();
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    is_alu = 1'b0; is_cmp = 1'b0; is_ld = 1'b0; is_str = 1'b0; taken = 1'b0;
    result = '0; cpsr_passthrough = '0; pc_rel = '0; rd_val_passthrough = '0;
    rd_num_passthrough = '0; md_passthrough = '0;
    tick(); tick();
    reset_outputs_check("reset");
    reset = 1'b0;
    tick();

    // Directed single-cycle ops, including back-to-back and priority overlap.
    issue(1'b1, 1'b0, 1'b0, 4'd1, 32'h7, 32'h0, 32'h0);
    idle(1);
    issue(1'b1, 1'b0, 1'b0, 4'd2, 32'h11, 32'h0, 32'h0);
    issue(1'b1, 1'b0, 1'b0, 4'd3, 32'h22, 32'h0, 32'h0);
    issue(1'b1, 1'b0, 1'b0, 4'd0, 32'h33, 32'h0, 32'h0);
    issue(1'b0, 1'b1, 1'b0, 4'd4, 32'h0, 32'h4000_0000, 32'h0);
    issue(1'b0, 1'b0, 1'b1, 4'd0, 32'h0, 32'h0, 32'h6);
    issue(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h9);
    issue(1'b1, 1'b1, 1'b1, 4'd9, 32'hA5, 32'h8000_0000, 32'h3);
    issue(1'b0, 1'b1, 1'b1, 4'd9, 32'h0, 32'h2000_0000, 32'h4);
    idle(1);

    // Ack while no access is outstanding has no effect.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_ignored", 96'({mem_req, in_ready}), 96'd1);

    // Memory ops: LD with waits, STR with fastest ack and a held instruction,
    // LD with priority noise, ack on the last allowed cycle, timeouts.
    mem_op(1'b1, 1'b0, 4'd8, 32'h0, 22'd9, 3, 32'hDEAD_BEEF, 1'b0);
    mem_op(1'b0, 1'b0, 4'd2, 32'h1234, 22'd11, 0, 32'h0, 1'b1);
    idle(1);
    mem_op(1'b1, 1'b1, 4'd6, 32'hFFFF_FFFF, 22'h3F_FFFF, 0, 32'h0BAD_F00D, 1'b0);
    mem_op(1'b1, 1'b0, 4'd7, 32'h0, 22'd100, TO - 1, 32'hCAFE_0001, 1'b0);
    mem_op(1'b1, 1'b0, 4'd7, 32'h0, 22'd101, TO, 32'hCAFE_0002, 1'b0);
    mem_op(1'b0, 1'b0, 4'd3, 32'h5555, 22'd102, 1000, 32'h0, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 4'd12, 32'h77, 32'h0, 32'h0);
    idle(1);

    // Reset in the middle of an outstanding load drops it without a write.
    is_ld = 1'b1; is_str = 1'b0; is_alu = 1'b0; is_cmp = 1'b0; taken = 1'b0;
    rd_num_passthrough = 4'd10; md_passthrough = 22'd55; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("pre_reset_req", 96'(mem_req), 96'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    err_exp = 1'b0;
    reset_outputs_check("mid_reset");
    tick();

    // Random mix of single-cycle bursts and memory accesses.
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        for (int b = 0; b < int'($urandom_range(1, 4)); b++)
          issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'($urandom), $urandom, $urandom, $urandom);
        idle(1);
      end else begin
        mem_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), $urandom,
               22'($urandom), int'($urandom_range(0, 6)), $urandom, 1'b0);
        idle(int'($urandom_range(0, 1)));
      end
    end

    idle(3);
    check("wb_rd_pending", 96'(wb_q.size()), 96'd0);
    check("wb_cpsr_pending", 96'(cpsr_q.size()), 96'd0);
    check("br_pending", 96'(br_q.size()), 96'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
